// File: rtl/uart_autobaud_det.sv
// uart_autobaud_det
//   Measures the incoming line rate from a 0x55 sync character and produces
//   the divisor for the baud generator (bclk period = dvsr clocks, 2^OVS_LOG2
//   bclk ticks per bit). Detection runs once per enable assertion.
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   enable      level: high = detect once, low = abort / rearm
//   rx          asynchronous serial line, idle high
//   dvsr        measured divisor, holds last good value
//   dvsr_valid  dvsr holds a good measurement (sticky until rst)
//   done        1-cycle pulse: new dvsr loaded
//   err         1-cycle pulse: measurement rejected
//   busy        high while armed or measuring
module uart_autobaud_det #(
    parameter int WIDTH    = 16,
    parameter int OVS_LOG2 = 4,
    parameter int CNT_W    = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             rx,
    output logic [WIDTH-1:0] dvsr,
    output logic             dvsr_valid,
    output logic             done,
    output logic             err,
    output logic             busy
);

    // The total T spans 8 bits, each bit is 2^OVS_LOG2 bclk periods.
    localparam int K = 3 + OVS_LOG2;
    localparam logic [CNT_W-1:0] MIN_I = CNT_W'(1) << OVS_LOG2;
    localparam logic [CNT_W:0]   HALF  = (CNT_W+1)'(1) << (K-1);
    localparam logic [CNT_W:0]   MAXQ  = {{(CNT_W+1-WIDTH){1'b0}}, {WIDTH{1'b1}}};

    typedef enum logic [2:0] {IDLE, ARMED, MEASURE, DONE_ST, ERR_ST, HOLD} state_t;

    state_t           state;
    logic             rx_s1, rx_s2, rx_prev;
    logic [CNT_W-1:0] t_cnt, i_cnt, i0;
    logic [3:0]       ecnt;

    logic             edge_det, fall;
    logic [CNT_W-1:0] t_nx, i_nx, i_diff;
    logic [CNT_W:0]   q_full;
    logic             q_ok;

    assign edge_det = rx_s2 ^ rx_prev;
    assign fall     = rx_prev & ~rx_s2;

    // Counts including the current cycle, so an interval ending on this
    // cycle's edge measures exactly the number of clocks between edges.
    assign t_nx   = (&t_cnt) ? t_cnt : t_cnt + CNT_W'(1);
    assign i_nx   = (&i_cnt) ? i_cnt : i_cnt + CNT_W'(1);
    assign i_diff = (i_nx >= i0) ? (i_nx - i0) : (i0 - i_nx);

    // Rounded divide of the 8-bit total by 2^K, evaluated on the final edge.
    assign q_full = ({1'b0, t_nx} + HALF) >> K;
    assign q_ok   = (q_full != '0) && (q_full <= MAXQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            t_cnt      <= '0;
            i_cnt      <= '0;
            i0         <= '0;
            ecnt       <= '0;
            dvsr       <= '0;
            dvsr_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            done    <= 1'b0;
            err     <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_s2) begin
                            state <= ARMED;
                            busy  <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (fall) begin
                            state <= MEASURE;
                            t_cnt <= '0;
                            i_cnt <= '0;
                            ecnt  <= '0;
                        end
                    end
                    MEASURE: begin
                        t_cnt <= t_nx;
                        i_cnt <= i_nx;
                        if (edge_det) begin
                            i_cnt <= '0;
                            ecnt  <= ecnt + 4'd1;
                            if (ecnt == 4'd0) begin
                                i0 <= i_nx;
                                if (i_nx < MIN_I) begin
                                    state <= ERR_ST;
                                    busy  <= 1'b0;
                                    err   <= 1'b1;
                                end
                            end else if (i_diff > (i0 >> 2)) begin
                                state <= ERR_ST;
                                busy  <= 1'b0;
                                err   <= 1'b1;
                            end else if (ecnt == 4'd7) begin
                                // 5th falling edge: T covers exactly 8 bits.
                                state <= DONE_ST;
                                busy  <= 1'b0;
                                if (q_ok) begin
                                    dvsr       <= q_full[WIDTH-1:0];
                                    dvsr_valid <= 1'b1;
                                    done       <= 1'b1;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                        end else if ((&t_nx) || (&i_nx)) begin
                            // Line stuck: counter saturated.
                            state <= ERR_ST;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end
                    end
                    DONE_ST, ERR_ST: state <= HOLD;
                    // HOLD ignores rx (including the trailing stop edge)
                    // until enable drops.
                    HOLD: state <= HOLD;
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud_det.sv
module tb_uart_autobaud_det;

    typedef struct {
        logic        is_err;
        logic [15:0] dvsr;
        logic        valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst, en0, en1, rx0, rx1;
    logic [15:0] dvsr0;
    logic [7:0]  dvsr1;
    logic val0, done0, err0, busy0;
    logic val1, done1, err1, busy1;

    int n_cmp = 0;
    int n_bad = 0;
    int blen[10];
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    uart_autobaud_det u0 (
        .clk(clk), .rst(rst), .enable(en0), .rx(rx0),
        .dvsr(dvsr0), .dvsr_valid(val0), .done(done0), .err(err0), .busy(busy0)
    );

    uart_autobaud_det #(.WIDTH(8), .OVS_LOG2(2), .CNT_W(13)) u1 (
        .clk(clk), .rst(rst), .enable(en1), .rx(rx1),
        .dvsr(dvsr1), .dvsr_valid(val1), .done(done1), .err(err1), .busy(busy1)
    );

    // Monitors: every pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (done0 || err0) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_bad++;
                $display("FAIL u0_unexpected_pulse done=%b err=%b dvsr=%0d valid=%b, required no pulse",
                         done0, err0, dvsr0, val0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if (err0 !== e.is_err || done0 !== !e.is_err || dvsr0 !== e.dvsr || val0 !== e.valid) begin
                    n_bad++;
                    $display("FAIL u0_pulse done=%b err=%b dvsr=%0d valid=%b, required done=%b err=%b dvsr=%0d valid=%b",
                             done0, err0, dvsr0, val0, !e.is_err, e.is_err, e.dvsr, e.valid);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done1 || err1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_bad++;
                $display("FAIL u1_unexpected_pulse done=%b err=%b dvsr=%0d valid=%b, required no pulse",
                         done1, err1, dvsr1, val1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                if (err1 !== e.is_err || done1 !== !e.is_err || {8'd0, dvsr1} !== e.dvsr || val1 !== e.valid) begin
                    n_bad++;
                    $display("FAIL u1_pulse done=%b err=%b dvsr=%0d valid=%b, required done=%b err=%b dvsr=%0d valid=%b",
                             done1, err1, dvsr1, val1, !e.is_err, e.is_err, e.dvsr, e.valid);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s got=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic set_len(input int b);
        for (int i = 0; i < 10; i++) blen[i] = b;
    endtask

    task automatic push(input bit sel, input logic is_err, input logic [15:0] d, input logic v);
        exp_t e;
        e.is_err = is_err;
        e.dvsr   = d;
        e.valid  = v;
        if (sel) q1.push_back(e);
        else q0.push_back(e);
    endtask

    // Sends the first nb bits of a start/data/stop frame, then idles high.
    task automatic send(input bit sel, input logic [7:0] ch, input int nb);
        logic [9:0] fr;
        fr = {1'b1, ch, 1'b0};
        for (int i = 0; i < nb; i++) begin
            if (sel) rx1 = fr[i];
            else rx0 = fr[i];
            tick(blen[i]);
        end
        if (sel) rx1 = 1'b1;
        else rx0 = 1'b1;
        tick(10);
    endtask

    task automatic wait_q(input bit sel, input int budget);
        int n;
        n = 0;
        while (((sel ? q1.size() : q0.size()) != 0) && n < budget) begin
            tick(1);
            n++;
        end
        if ((sel ? q1.size() : q0.size()) != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL u%0d_pulse_wait pending=%0d, required 0 within %0d cycles",
                     sel, sel ? q1.size() : q0.size(), budget);
            if (sel) q1.delete();
            else q0.delete();
        end
        tick(3);
    endtask

    task automatic rearm(input bit sel);
        if (sel) en1 = 1'b0;
        else en0 = 1'b0;
        tick(3);
        if (sel) en1 = 1'b1;
        else en0 = 1'b1;
        tick(5);
    endtask

    initial begin
        rst = 1'b1; en0 = 1'b0; en1 = 1'b0; rx0 = 1'b1; rx1 = 1'b1;
        tick(3);
        chk("rst_dvsr0", 32'(dvsr0), 0);
        chk("rst_valid0", 32'(val0), 0);
        chk("rst_done0", 32'(done0), 0);
        chk("rst_err0", 32'(err0), 0);
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_dvsr1", 32'(dvsr1), 0);
        chk("rst_busy1", 32'(busy1), 0);
        rst = 1'b0;
        en0 = 1'b1; en1 = 1'b1;
        tick(5);
        chk("armed_busy0", 32'(busy0), 1);

        // Nominal: 1600 clk/bit -> T=12800 -> dvsr=100.
        set_len(1600);
        push(0, 1'b0, 16'd100, 1'b1);
        send(0, 8'h55, 10);
        wait_q(0, 100);
        chk("nominal_busy", 32'(busy0), 0);

        // Jitter within tolerance, T=12840 -> (12840+64)>>7 = 100.
        rearm(0);
        set_len(1600);
        blen[1] = 1750; blen[2] = 1450; blen[4] = 1750; blen[5] = 1450; blen[6] = 1640;
        push(0, 1'b0, 16'd100, 1'b1);
        send(0, 8'h55, 10);
        wait_q(0, 100);

        // Second interval 1600+450 exceeds the 400-clk window.
        rearm(0);
        set_len(1600);
        blen[1] = 2050;
        push(0, 1'b1, 16'd100, 1'b1);
        send(0, 8'h55, 3);
        wait_q(0, 100);

        // Wrong char 0x0F: second interval is 4 bits.
        rearm(0);
        set_len(320);
        push(0, 1'b1, 16'd100, 1'b1);
        send(0, 8'h0F, 10);
        wait_q(0, 100);
        chk("wrongchar_busy", 32'(busy0), 0);
        chk("wrongchar_dvsr", 32'(dvsr0), 100);
        chk("wrongchar_valid", 32'(val0), 1);

        // Abort after edge #4: no pulse, busy drops next cycle.
        rearm(0);
        rx0 = 1'b0; tick(320);
        rx0 = 1'b1; tick(320);
        rx0 = 1'b0; tick(320);
        rx0 = 1'b1; tick(320);
        rx0 = 1'b0; tick(50);
        chk("abort_busy_before", 32'(busy0), 1);
        en0 = 1'b0;
        tick(1);
        chk("abort_busy_after", 32'(busy0), 0);
        rx0 = 1'b1;
        tick(400);
        chk("abort_dvsr", 32'(dvsr0), 100);
        chk("abort_valid", 32'(val0), 1);

        // One-shot: second char in HOLD ignored until enable toggles.
        en0 = 1'b1;
        tick(5);
        set_len(320);
        push(0, 1'b0, 16'd20, 1'b1);
        send(0, 8'h55, 10);
        wait_q(0, 100);
        set_len(240);
        send(0, 8'h55, 10);
        tick(20);
        chk("hold_dvsr", 32'(dvsr0), 20);
        chk("hold_busy", 32'(busy0), 0);
        rearm(0);
        push(0, 1'b0, 16'd15, 1'b1);
        send(0, 8'h55, 10);
        wait_q(0, 100);

        // 10 clk/bit: first interval below 16.
        rearm(0);
        set_len(10);
        push(0, 1'b1, 16'd15, 1'b1);
        send(0, 8'h55, 10);
        wait_q(0, 100);

        // Small instance: 64 clk/bit -> (512+16)>>5 = 16.
        set_len(64);
        push(1, 1'b0, 16'd16, 1'b1);
        send(1, 8'h55, 10);
        wait_q(1, 100);

        // 1023 clk/bit -> q=(8184+16)>>5 = 256 > 255 -> err.
        rearm(1);
        set_len(1023);
        push(1, 1'b1, 16'd16, 1'b1);
        send(1, 8'h55, 10);
        wait_q(1, 100);

        // Timeout: line stuck low saturates the 13-bit counters.
        rearm(1);
        push(1, 1'b1, 16'd16, 1'b1);
        rx1 = 1'b0;
        wait_q(1, 9000);
        chk("timeout_busy", 32'(busy1), 0);
        rx1 = 1'b1;
        tick(10);

        // Reset mid-measurement clears everything, including dvsr_valid.
        rearm(0);
        set_len(320);
        send(0, 8'h55, 3);
        chk("midrst_busy_before", 32'(busy0), 1);
        rst = 1'b1;
        tick(1);
        chk("midrst_dvsr", 32'(dvsr0), 0);
        chk("midrst_valid", 32'(val0), 0);
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_done_err", 32'({done0, err0}), 0);
        rst = 1'b0;
        tick(10);
        chk("queues_empty", 32'(q0.size() + q1.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
